// File: rtl/expr_eval_stack_if.sv
// Token and result handshake bundle for the infix expression evaluator.
// The source/consumer side uses master; the evaluator uses slave.
interface expr_eval_stack_if #(
  parameter int WIDTH = 8
);
  logic             tok_valid;
  logic             tok_ready;
  logic [1:0]       tok_kind;
  logic [WIDTH-1:0] tok_data;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             err_div0;
  logic             err_ovf;
  logic             err_syntax;

  modport master (
    output tok_valid, tok_kind, tok_data, res_ready,
    input  tok_ready, res_valid, res_data, err_div0, err_ovf, err_syntax
  );

  modport slave (
    input  tok_valid, tok_kind, tok_data, res_ready,
    output tok_ready, res_valid, res_data, err_div0, err_ovf, err_syntax
  );
endinterface

// File: rtl/expr_eval_stack.sv
// Infix expression evaluator: operand and operator stacks with precedence,
// parentheses, sticky error flags and a result handshake.
module expr_eval_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  expr_eval_stack_if.slave bus,
  output logic          busy,
  output logic [CW-1:0] opnd_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_ACCEPT  = 2'd0,
    S_RESOLVE = 2'd1,
    S_FLUSH   = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_LP  = 3'd4;
  localparam logic [2:0] OP_RP  = 3'd5;

  localparam logic [CW-1:0] ZERO_C = CW'(0);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [CW-1:0] TWO_C  = CW'(2);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opnd_stk_q [DEPTH];
  logic [WIDTH-1:0] opnd_stk_d [DEPTH];
  logic [2:0]       op_stk_q [DEPTH];
  logic [2:0]       op_stk_d [DEPTH];
  logic [CW-1:0]    opnd_cnt_q, opnd_cnt_d;
  logic [CW-1:0]    op_cnt_q, op_cnt_d;
  logic [2:0]       pend_q, pend_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             err_div0_q, err_div0_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_syn_q, err_syn_d;
  logic             tok_ready_q, tok_ready_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q, busy_d;

  logic [AW-1:0]    opnd_top_idx_s, opnd_sec_idx_s, opnd_push_idx_s;
  logic [AW-1:0]    op_top_idx_s, op_push_idx_s;
  logic [WIDTH-1:0] a_s, b_s, alu_res_s;
  logic [2:0]       op_top_s;
  logic             alu_div0_s;
  logic             reduce_s, set_syn_s, set_ovf_s, err_s;

  function automatic logic is_high(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  assign opnd_top_idx_s  = AW'(opnd_cnt_q - ONE_C);
  assign opnd_sec_idx_s  = AW'(opnd_cnt_q - TWO_C);
  assign opnd_push_idx_s = AW'(opnd_cnt_q);
  assign op_top_idx_s    = AW'(op_cnt_q - ONE_C);
  assign op_push_idx_s   = AW'(op_cnt_q);
  assign a_s             = opnd_stk_q[opnd_sec_idx_s];
  assign b_s             = opnd_stk_q[opnd_top_idx_s];
  assign op_top_s        = op_stk_q[op_top_idx_s];

  // ALU for the reduce step; division by zero yields all-ones and flags it.
  always_comb begin
    alu_res_s  = {WIDTH{1'b0}};
    alu_div0_s = 1'b0;
    case (op_top_s)
      OP_ADD: alu_res_s = a_s + b_s;
      OP_SUB: alu_res_s = a_s - b_s;
      OP_MUL: alu_res_s = a_s * b_s;
      OP_DIV: begin
        if (b_s == {WIDTH{1'b0}}) begin
          alu_res_s  = {WIDTH{1'b1}};
          alu_div0_s = 1'b1;
        end else begin
          alu_res_s  = a_s / b_s;
        end
      end
      default: alu_res_s = {WIDTH{1'b0}};
    endcase
  end

  // Next-state logic: one stack action per cycle, errors force DONE.
  always_comb begin
    state_d    = state_q;
    opnd_stk_d = opnd_stk_q;
    op_stk_d   = op_stk_q;
    opnd_cnt_d = opnd_cnt_q;
    op_cnt_d   = op_cnt_q;
    pend_d     = pend_q;
    res_data_d = res_data_q;
    err_div0_d = err_div0_q;
    err_ovf_d  = err_ovf_q;
    err_syn_d  = err_syn_q;
    reduce_s   = 1'b0;
    set_syn_s  = 1'b0;
    set_ovf_s  = 1'b0;

    case (state_q)
      S_ACCEPT: begin
        if (bus.tok_valid) begin
          case (bus.tok_kind)
            2'b00: begin
              if (opnd_cnt_q == FULL_C) begin
                set_ovf_s = 1'b1;
              end else begin
                opnd_stk_d[opnd_push_idx_s] = bus.tok_data;
                opnd_cnt_d = opnd_cnt_q + ONE_C;
              end
            end
            2'b01: begin
              if (bus.tok_data[2:0] <= OP_RP) begin
                pend_d  = bus.tok_data[2:0];
                state_d = S_RESOLVE;
              end else begin
                set_syn_s = 1'b1;
              end
            end
            2'b10:   state_d = S_FLUSH;
            default: set_syn_s = 1'b1;
          endcase
        end else begin
          state_d = S_ACCEPT;
        end
      end
      S_RESOLVE: begin
        if (pend_q == OP_LP) begin
          if (op_cnt_q == FULL_C) begin
            set_ovf_s = 1'b1;
          end else begin
            op_stk_d[op_push_idx_s] = OP_LP;
            op_cnt_d = op_cnt_q + ONE_C;
            state_d  = S_ACCEPT;
          end
        end else if (pend_q == OP_RP) begin
          if (op_cnt_q == ZERO_C) begin
            set_syn_s = 1'b1;
          end else if (op_top_s == OP_LP) begin
            op_cnt_d = op_cnt_q - ONE_C;
            state_d  = S_ACCEPT;
          end else begin
            reduce_s = 1'b1;
          end
        end else if ((op_cnt_q != ZERO_C) && (op_top_s != OP_LP) &&
                     (is_high(op_top_s) || !is_high(pend_q))) begin
          // Left associativity: equal precedence on top reduces first.
          reduce_s = 1'b1;
        end else if (op_cnt_q == FULL_C) begin
          set_ovf_s = 1'b1;
        end else begin
          op_stk_d[op_push_idx_s] = pend_q;
          op_cnt_d = op_cnt_q + ONE_C;
          state_d  = S_ACCEPT;
        end
      end
      S_FLUSH: begin
        if (op_cnt_q != ZERO_C) begin
          if (op_top_s == OP_LP) begin
            set_syn_s = 1'b1;
          end else begin
            reduce_s = 1'b1;
          end
        end else if (opnd_cnt_q == ONE_C) begin
          res_data_d = b_s;
          state_d    = S_DONE;
        end else begin
          set_syn_s = 1'b1;
        end
      end
      S_DONE: begin
        if (bus.res_ready) begin
          opnd_cnt_d = ZERO_C;
          op_cnt_d   = ZERO_C;
          res_data_d = {WIDTH{1'b0}};
          err_div0_d = 1'b0;
          err_ovf_d  = 1'b0;
          err_syn_d  = 1'b0;
          state_d    = S_ACCEPT;
        end else begin
          state_d    = S_DONE;
        end
      end
      default: state_d = S_ACCEPT;
    endcase

    if (reduce_s && (opnd_cnt_q >= TWO_C)) begin
      opnd_stk_d[opnd_sec_idx_s] = alu_res_s;
      opnd_cnt_d = opnd_cnt_q - ONE_C;
      op_cnt_d   = op_cnt_q - ONE_C;
      err_div0_d = err_div0_q | alu_div0_s;
    end else begin
      set_syn_s  = set_syn_s | reduce_s;
    end

    err_s       = set_ovf_s | set_syn_s;
    err_ovf_d   = err_ovf_d | set_ovf_s;
    err_syn_d   = err_syn_d | set_syn_s;
    res_data_d  = err_s ? {WIDTH{1'b0}} : res_data_d;
    state_d     = err_s ? S_DONE : state_d;

    tok_ready_d = (state_d == S_ACCEPT);
    res_valid_d = (state_d == S_DONE);
    busy_d      = (state_d == S_RESOLVE) || (state_d == S_FLUSH);
  end

  // State, stacks and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_ACCEPT;
      opnd_stk_q  <= '{default: {WIDTH{1'b0}}};
      op_stk_q    <= '{default: 3'd0};
      opnd_cnt_q  <= ZERO_C;
      op_cnt_q    <= ZERO_C;
      pend_q      <= 3'd0;
      res_data_q  <= {WIDTH{1'b0}};
      err_div0_q  <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_syn_q   <= 1'b0;
      tok_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      opnd_stk_q  <= opnd_stk_d;
      op_stk_q    <= op_stk_d;
      opnd_cnt_q  <= opnd_cnt_d;
      op_cnt_q    <= op_cnt_d;
      pend_q      <= pend_d;
      res_data_q  <= res_data_d;
      err_div0_q  <= err_div0_d;
      err_ovf_q   <= err_ovf_d;
      err_syn_q   <= err_syn_d;
      tok_ready_q <= tok_ready_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.tok_ready  = tok_ready_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.err_div0   = err_div0_q;
  assign bus.err_ovf    = err_ovf_q;
  assign bus.err_syntax = err_syn_q;
  assign busy           = busy_q;
  assign opnd_cnt       = opnd_cnt_q;

endmodule

// File: tb/tb_expr_eval_stack.sv
// Directed bench for expr_eval_stack: a DEPTH=8 and a DEPTH=2 instance,
// expressions written as character strings with hand-computed results.
module tb_expr_eval_stack;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy_a, busy_b;
  logic [3:0] cnt_a;
  logic [1:0] cnt_b;

  int vec_cnt     = 0;
  int n_checks    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  expr_eval_stack_if #(.WIDTH(W)) ifa ();
  expr_eval_stack_if #(.WIDTH(W)) ifb ();

  expr_eval_stack #(.WIDTH(W), .DEPTH(8)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave), .busy(busy_a), .opnd_cnt(cnt_a)
  );
  expr_eval_stack #(.WIDTH(W), .DEPTH(2)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave), .busy(busy_b), .opnd_cnt(cnt_b)
  );

  // expr: token characters; lat/stall of 0 means "not checked"
  typedef struct packed {
    logic [127:0] expr;
    logic         sel;
    logic [7:0]   res;
    logic         div0;
    logic         ovf;
    logic         syn;
    logic [3:0]   lat;
    logic [3:0]   stall;
  } vec_t;

  vec_t vecs [20];
  int   nv;

  function automatic logic [127:0] pk(input string s);
    logic [127:0] r;
    r = 128'd0;
    for (int i = 0; i < s.len(); i++) r = {r[119:0], s[i]};
    return r;
  endfunction

  function automatic vec_t mk(input string e, input logic sel, input logic [7:0] res,
                              input logic div0, input logic ovf, input logic syn,
                              input logic [3:0] lat, input logic [3:0] stall);
    vec_t v;
    v.expr = pk(e); v.sel = sel; v.res = res; v.div0 = div0; v.ovf = ovf;
    v.syn = syn; v.lat = lat; v.stall = stall;
    return v;
  endfunction

  function automatic logic rd_ready(input logic sel);
    return sel ? ifb.tok_ready : ifa.tok_ready;
  endfunction
  function automatic logic rd_valid(input logic sel);
    return sel ? ifb.res_valid : ifa.res_valid;
  endfunction
  function automatic logic [7:0] rd_res(input logic sel);
    return sel ? ifb.res_data : ifa.res_data;
  endfunction
  function automatic logic [2:0] rd_flags(input logic sel);
    return sel ? {ifb.err_div0, ifb.err_ovf, ifb.err_syntax}
               : {ifa.err_div0, ifa.err_ovf, ifa.err_syntax};
  endfunction
  function automatic logic rd_busy(input logic sel);
    return sel ? busy_b : busy_a;
  endfunction
  function automatic logic [3:0] rd_cnt(input logic sel);
    return sel ? {2'b00, cnt_b} : cnt_a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic v, input logic [1:0] k, input logic [7:0] d);
    if (sel) begin
      ifb.tok_valid = v; ifb.tok_kind = k; ifb.tok_data = d;
    end else begin
      ifa.tok_valid = v; ifa.tok_kind = k; ifa.tok_data = d;
    end
  endtask

  task automatic set_rr(input logic sel, input logic v);
    if (sel) ifb.res_ready = v;
    else     ifa.res_ready = v;
  endtask

  // Called at a negedge; returns at the negedge after the token is taken.
  task automatic send_tok(input logic sel, input logic [1:0] k, input logic [7:0] d,
                          output int waits, output logic aborted);
    waits = 0;
    aborted = 1'b0;
    drive(sel, 1'b1, k, d);
    while (!rd_ready(sel) && !aborted) begin
      if (rd_valid(sel) || waits > 50) aborted = 1'b1;
      else begin
        @(negedge clk);
        waits++;
      end
    end
    if (!aborted) @(negedge clk);
    drive(sel, 1'b0, 2'b00, 8'h00);
  endtask

  task automatic run_expr(input logic sel, input logic [127:0] e,
                          output int lat, output int stalls);
    logic [7:0] c;
    logic [1:0] k;
    logic [7:0] d;
    logic       ab;
    int         w;
    stalls = 0;
    ab = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      c = e[i*8 +: 8];
      if (c != 8'd0 && !ab) begin
        k = 2'b01;
        d = 8'd0;
        case (c)
          "+": d = 8'd0;
          "-": d = 8'd1;
          "*": d = 8'd2;
          "/": d = 8'd3;
          "(": d = 8'd4;
          ")": d = 8'd5;
          "?": d = 8'd6;
          "!": k = 2'b11;
          "#": k = 2'b10;
          default: begin k = 2'b00; d = c - 8'h30; end
        endcase
        send_tok(sel, k, d, w, ab);
        stalls += w;
      end
    end
    lat = 0;
    while (!rd_valid(sel) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("res_valid_seen", 32'(rd_valid(sel)), 32'd1);
  endtask

  task automatic apply_vec(input int idx, input vec_t v, input int hold);
    int lat, stalls;
    run_expr(v.sel, v.expr, lat, stalls);
    vec_cnt++;
    chk($sformatf("v%0d_res", idx), 32'(rd_res(v.sel)), 32'(v.res));
    chk($sformatf("v%0d_flags", idx), 32'(rd_flags(v.sel)), 32'({v.div0, v.ovf, v.syn}));
    if (v.lat != 4'd0)   chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
    if (v.stall != 4'd0) chk($sformatf("v%0d_stall", idx), 32'(stalls), 32'(v.stall));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk($sformatf("v%0d_hold_valid", idx), 32'(rd_valid(v.sel)), 32'd1);
      chk($sformatf("v%0d_hold_res", idx), 32'(rd_res(v.sel)), 32'(v.res));
      chk($sformatf("v%0d_hold_ready", idx), 32'(rd_ready(v.sel)), 32'd0);
    end
    set_rr(v.sel, 1'b1);
    @(negedge clk);
    set_rr(v.sel, 1'b0);
    chk($sformatf("v%0d_post_valid", idx), 32'(rd_valid(v.sel)), 32'd0);
    chk($sformatf("v%0d_post_ready", idx), 32'(rd_ready(v.sel)), 32'd1);
    chk($sformatf("v%0d_post_flags", idx), 32'(rd_flags(v.sel)), 32'd0);
    chk($sformatf("v%0d_post_cnt", idx), 32'(rd_cnt(v.sel)), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag, input logic sel);
    chk({tag, "_ready"}, 32'(rd_ready(sel)), 32'd1);
    chk({tag, "_valid"}, 32'(rd_valid(sel)), 32'd0);
    chk({tag, "_res"},   32'(rd_res(sel)),   32'd0);
    chk({tag, "_flags"}, 32'(rd_flags(sel)), 32'd0);
    chk({tag, "_busy"},  32'(rd_busy(sel)),  32'd0);
    chk({tag, "_cnt"},   32'(rd_cnt(sel)),   32'd0);
  endtask

  initial begin
    int w;
    logic ab;

    nv = 0;
    vecs[nv++] = mk("2+3*4#",     1'b0, 8'd14,  1'b0, 1'b0, 1'b0, 4'd3, 4'd2);
    vecs[nv++] = mk("(2+3)*4#",   1'b0, 8'd20,  1'b0, 1'b0, 1'b0, 4'd2, 4'd5);
    vecs[nv++] = mk("9-4-3#",     1'b0, 8'd2,   1'b0, 1'b0, 1'b0, 4'd2, 4'd3);
    vecs[nv++] = mk("3-5#",       1'b0, 8'd254, 1'b0, 1'b0, 1'b0, 4'd2, 4'd0);
    vecs[nv++] = mk("7/0+1#",     1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 4'd2, 4'd0);
    vecs[nv++] = mk("8/3#",       1'b0, 8'd2,   1'b0, 1'b0, 1'b0, 4'd2, 4'd0);
    vecs[nv++] = mk("8/2/2#",     1'b0, 8'd2,   1'b0, 1'b0, 1'b0, 4'd2, 4'd0);
    vecs[nv++] = mk("2*(3+4)-1#", 1'b0, 8'd13,  1'b0, 1'b0, 1'b0, 4'd2, 4'd0);
    vecs[nv++] = mk("1+#",        1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    vecs[nv++] = mk("1)#",        1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    vecs[nv++] = mk("(1#",        1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    vecs[nv++] = mk("12#",        1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    vecs[nv++] = mk("!",          1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    vecs[nv++] = mk("5?#",        1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    vecs[nv++] = mk("1+2+3#",     1'b1, 8'd6,   1'b0, 1'b0, 1'b0, 4'd2, 4'd0);
    vecs[nv++] = mk("(((1#",      1'b1, 8'd0,   1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    vecs[nv++] = mk("123#",       1'b1, 8'd0,   1'b0, 1'b1, 1'b0, 4'd0, 4'd0);

    rst = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 8'h00);
    drive(1'b1, 1'b0, 2'b00, 8'h00);
    set_rr(1'b0, 1'b0);
    set_rr(1'b1, 1'b0);
    #12;
    chk_reset_vals("rst_a", 1'b0);
    chk_reset_vals("rst_b", 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < nv; i++) apply_vec(i, vecs[i], 0);

    // Result must stay frozen while the consumer stalls
    apply_vec(nv, mk("9*9*9#", 1'b0, 8'd217, 1'b0, 1'b0, 1'b0, 4'd2, 4'd0), 5);

    // Reset in the middle of an expression, while RESOLVE is busy
    send_tok(1'b0, 2'b00, 8'd5, w, ab);
    send_tok(1'b0, 2'b01, 8'd0, w, ab);
    vec_cnt++;
    chk("mid_busy", 32'(busy_a), 32'd1);
    chk("mid_cnt", 32'(cnt_a), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk_reset_vals("async_rst", 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    apply_vec(nv + 1, mk("5#", 1'b0, 8'd5, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/expr_eval_stack.md
# expr_eval_stack

Parametrised infix expression evaluator for the calculator datapath. Accepts a token stream (operands, operators, parentheses, end marker) over a valid/ready handshake. Evaluates it with precedence using an operand stack and an operator stack, each `DEPTH` entries deep. Returns a `WIDTH`-bit result with error flags. It replaces the fixed-width controller/datapath pair and adds parentheses, error reporting and a result handshake.

## Interface
- `WIDTH`, 8: operand/result width in bits (≥4).
- `DEPTH`, 8: entries per stack (≥2); `CW = $clog2(DEPTH+1)`.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `tok_valid`  in  1  token present.
- `tok_ready`  out  1  block can accept a token.
- `tok_kind`  in  2  00 operand, 01 operator, 10 end ('#'), 11 illegal.
- `tok_data`  in  WIDTH  operand value; for operators `[2:0]`: 0 '+', 1 '-', 2 '*', 3 '/', 4 '(', 5 ')', 6–7 illegal.
- `res_valid`  out  1  result/flags valid.
- `res_ready`  in  1  consumer takes result.
- `res_data`  out  WIDTH  result.
- `err_div0`, `err_ovf`, `err_syntax`  out  1 each  sticky error flags, valid with `res_valid`.
- `busy`  out  1  high in RESOLVE/FLUSH.
- `opnd_cnt`  out  CW  current operand stack occupancy (debug/LED).

## Operation
- States:
  - ACCEPT (reset state): `tok_ready`=1. On handshake:
    - Operand is pushed; stay in ACCEPT.
    - Operator is latched into the pending register; go to RESOLVE.
    - End marker goes to FLUSH.
    - Illegal kind or code sets `err_syntax` and goes to DONE.
  - RESOLVE: one action per cycle.
    - '(' is pushed; return to ACCEPT.
    - ')' with '(' on top: pop it, return to ACCEPT. With another operator on top: reduce. With an empty operator stack: `err_syntax`, go to DONE.
    - '+ - * /': if the top is a non-'(' operator with precedence ≥ pending, reduce. Otherwise push pending and return to ACCEPT.
    - Precedence: '*' and '/' are above '+' and '-'. All operators are left-associative.
  - FLUSH: reduce one operator per cycle while the operator stack is non-empty. A '(' found on top sets `err_syntax` and goes to DONE. With the operator stack empty, `opnd_cnt`==1 loads `res_data` from the top operand; any other count sets `err_syntax`. Then go to DONE.
  - DONE: `res_valid`=1 and `tok_ready`=0. On `res_valid && res_ready`: clear both stacks, clear the flags, go to ACCEPT next cycle.
- Reduce (1 cycle):
  - Pop operator `op`, right operand `b` (top) and left operand `a`; push `a op b`.
  - Fewer than 2 operands: `err_syntax`, go to DONE.
- Arithmetic (unsigned, modulo 2^WIDTH):
  - '+' and '-' wrap.
  - '*' keeps the low `WIDTH` bits.
  - '/' truncates.
  - `b`==0 pushes all-ones, sets `err_div0` and continues evaluation.
- Push to a full stack (operand or operator): set `err_ovf`, go to DONE.
- On `err_ovf` or `err_syntax`, `res_data`=0.
- Flags are sticky until the DONE handshake or reset.

## Timing
- Reset (async, `rst`=0) values:
  - state ACCEPT, stacks empty, `opnd_cnt`=0.
  - `tok_ready`=1, `res_valid`=0, `res_data`=0, all flags 0, `busy`=0.
- Reset asserted mid-expression aborts immediately; no partial result is emitted.
- Token acceptance:
  - An operand costs 1 cycle.
  - An operator costs 1 accept cycle plus (reductions + 1) RESOLVE cycles; `tok_ready` is low during RESOLVE.
- Result latency: `res_valid` rises on the (N+1)th rising edge after '#' is accepted, where N is the number of stacked operators.
- In DONE, `res_data` and the flags are stable until the handshake.
- `tok_valid` while `tok_ready`=0 is ignored; the token must be held by the source.
- An error detected in any state takes effect at that cycle's edge: `res_valid` is high on the next cycle.

## Test plan
- Tokens 2 + 3 * 4 #, back-to-back valid -> `res_data`=14, no flags, `res_valid` on the 3rd edge after '#' accept, `tok_ready` low for exactly 1 cycle after each operator.
- ( 2 + 3 ) * 4 # -> 20. Then 9 - 4 - 3 # -> 2 (left associativity). Then 3 - 5 # at `WIDTH`=8 -> 254.
- 7 / 0 + 1 # -> `res_data`=0 (0xFF+1 wraps), `err_div0`=1. Next expression 8 / 3 # -> 2 with `err_div0` cleared.
- `DEPTH`=2: 1 + 2 + 3 # needs at most 2 operands -> 6. ( ( ( 1 # -> third '(' sets `err_ovf`, `res_data`=0.
- Syntax errors, each giving `err_syntax`=1, `res_data`=0:
  - 1 + #
  - 1 ) #
  - ( 1 #
  - 1 2 #
  - `tok_kind`=11
- Hold `res_ready`=0 for 5 cycles in DONE -> `res_valid`/`res_data` stable. Pull `rst` low mid-expression -> all outputs at reset values asynchronously, and the next expression 5 # -> 5.
